// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sandbox blocks: sample width, stimulus mode
// encodings, stimulus FSM state encoding and the PRBS LFSR tap mask.
package fir_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        MODE_IMPULSE = 2'd0,
        MODE_STEP    = 2'd1,
        MODE_SQUARE  = 2'd2,
        MODE_PRBS    = 2'd3
    } fir_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } fir_state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 as feedback taps on state bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/fir_lfsr8.sv
// 8-bit Fibonacci LFSR: loads SEED on rst, shifts left by one step per enable.
module fir_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);
    import fir_pkg::*;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/fir_stim_gen.sv
// Programmable impulse/step/square/PRBS sample source for the fir_filter input.
// Handshake: x_valid is high for exactly one cycle per sample; x_out is only a new sample while x_valid=1.
module fir_stim_gen #(
    parameter int         DATA_W    = fir_pkg::DATA_W,
    parameter int         LEN_W     = 16,
    parameter int         DIV       = 1,
    parameter int         HALF_PER  = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic signed [DATA_W-1:0] amp,
    input  logic [LEN_W-1:0]         length,
    output logic signed [DATA_W-1:0] x_out,
    output logic                     x_valid,
    output logic                     busy,
    output logic                     done,
    output fir_pkg::fir_state_t      dbg_state
);
    import fir_pkg::*;

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HP_W  = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;

    fir_state_t               state_q, state_d;
    fir_mode_t                mode_q;
    logic signed [DATA_W-1:0] amp_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         idx_q;
    logic [DIV_W-1:0]         div_q;
    logic [HP_W-1:0]          sq_cnt_q;
    logic                     sq_neg_q;
    logic signed [DATA_W-1:0] last_q;
    logic [7:0]               lfsr_q;

    logic                     strobe;
    logic                     last_idx;
    logic signed [DATA_W:0]   neg_wide;
    logic signed [DATA_W-1:0] neg_amp;
    logic signed [DATA_W-1:0] sample;

    // Negation at DATA_W+1 bits so the most negative amplitude saturates
    // to the most positive code instead of wrapping back onto itself.
    always_comb begin
        neg_wide = -{amp_q[DATA_W-1], amp_q};
        if (neg_wide[DATA_W] != neg_wide[DATA_W-1]) begin
            neg_amp = neg_wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            neg_amp = neg_wide[DATA_W-1:0];
        end
    end

    assign strobe   = (state_q == ST_RUN) && (div_q == '0);
    assign last_idx = (idx_q == len_q - LEN_W'(1));

    always_comb begin
        sample = '0;
        case (mode_q)
            MODE_IMPULSE: sample = (idx_q == '0) ? amp_q : '0;
            MODE_STEP:    sample = amp_q;
            MODE_SQUARE:  sample = sq_neg_q ? neg_amp : amp_q;
            MODE_PRBS:    sample = lfsr_q[0] ? amp_q : neg_amp;
            default:      sample = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (length == '0) ? ST_FIN : ST_RUN;
            ST_RUN:  if (strobe && last_idx) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_RUN);
        done      = (state_q == ST_FIN);
        x_valid   = strobe;
        x_out     = '0;
        dbg_state = state_q;
        if (state_q == ST_RUN) begin
            x_out = strobe ? sample : last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_IMPULSE;
            amp_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            div_q    <= '0;
            sq_cnt_q <= '0;
            sq_neg_q <= 1'b0;
            last_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                mode_q   <= fir_mode_t'(mode);
                amp_q    <= amp;
                len_q    <= length;
                idx_q    <= '0;
                div_q    <= '0;
                sq_cnt_q <= '0;
                sq_neg_q <= 1'b0;
                last_q   <= '0;
            end else if (state_q == ST_RUN) begin
                div_q <= (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + DIV_W'(1);
                if (strobe) begin
                    idx_q  <= idx_q + LEN_W'(1);
                    last_q <= sample;
                    if (sq_cnt_q == HP_W'(HALF_PER - 1)) begin
                        sq_cnt_q <= '0;
                        sq_neg_q <= ~sq_neg_q;
                    end else begin
                        sq_cnt_q <= sq_cnt_q + HP_W'(1);
                    end
                end
            end
        end
    end

    // The PRBS sequence only moves when a PRBS sample is actually emitted.
    fir_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (strobe && (mode_q == MODE_PRBS)),
        .q   (lfsr_q)
    );

endmodule

// File: tb/tb_fir_stim_gen.sv
// Directed bench for fir_stim_gen at DIV=1 and DIV=3 against a sample-list model.
module tb_fir_stim_gen;
  import fir_pkg::*;

  localparam int HP = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic signed [7:0] amp = 8'sd0;
  logic [15:0]       length = 16'd0;

  logic signed [7:0] x1, x3;
  logic              v1, v3, b1, b3, d1, d3;
  fir_state_t        s1, s3;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fir_stim_gen #(.DATA_W(8), .LEN_W(16), .DIV(1), .HALF_PER(HP), .LFSR_SEED(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amp(amp), .length(length),
    .x_out(x1), .x_valid(v1), .busy(b1), .done(d1), .dbg_state(s1)
  );

  fir_stim_gen #(.DATA_W(8), .LEN_W(16), .DIV(3), .HALF_PER(HP), .LFSR_SEED(8'hA5)) dut3 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amp(amp), .length(length),
    .x_out(x3), .x_valid(v3), .busy(b3), .done(d3), .dbg_state(s3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] m_lfsr = 8'hA5;
  int         m_phase[2] = '{0, 0};   // 0 idle, 1 running, 2 finishing
  int         m_cyc[2]   = '{0, 0};
  int         m_len[2]   = '{0, 0};
  int         divs[2]    = '{1, 3};

  function automatic logic [7:0] neg_sat(input logic signed [7:0] a);
    int na;
    na = -int'(a);
    if (na > 127) na = 127;
    return 8'(na);
  endfunction

  task automatic build_samples(input int md, input logic signed [7:0] a, input int len);
    logic [7:0] s;
    exp_q.delete();
    for (int n = 0; n < len; n++) begin
      case (md)
        0: s = (n == 0) ? a : 8'd0;
        1: s = a;
        2: s = (((n / HP) % 2) == 1) ? neg_sat(a) : a;
        default: begin
          s = m_lfsr[0] ? a : neg_sat(a);
          m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
      endcase
      exp_q.push_back(s);
    end
  endtask

  task automatic model_step();
    bit acc;
    acc = 0;
    if (rst) m_lfsr = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_phase[k] = 0;
      end else begin
        case (m_phase[k])
          0: if (start) begin
               if (length == 16'd0) m_phase[k] = 2;
               else begin
                 m_phase[k] = 1; m_cyc[k] = 0; m_len[k] = int'(length); acc = 1;
               end
             end
          1: if (m_cyc[k] == (m_len[k] - 1) * divs[k]) m_phase[k] = 2;
             else m_cyc[k]++;
          default: m_phase[k] = 0;
        endcase
      end
    end
    if (acc) build_samples(int'(mode), amp, int'(length));
  endtask

  // ---------------- scoreboard / compare ----------------
  logic [7:0] cap_q[$];
  int v3_cnt = 0, b3_cnt = 0, d1_cnt = 0;

  always @(posedge clk) begin
    logic [7:0] ex;
    logic       ev;
    fir_state_t es;
    model_step();
    #1;
    for (int k = 0; k < 2; k++) begin
      ev = (m_phase[k] == 1) && ((m_cyc[k] % divs[k]) == 0);
      ex = (m_phase[k] == 1) ? exp_q[m_cyc[k] / divs[k]] : 8'd0;
      es = (m_phase[k] == 1) ? ST_RUN : (m_phase[k] == 2) ? ST_FIN : ST_IDLE;
      check($sformatf("x_out[div%0d]", divs[k]), {24'd0, (k == 0) ? x1 : x3}, {24'd0, ex});
      check($sformatf("x_valid[div%0d]", divs[k]), {31'd0, (k == 0) ? v1 : v3}, {31'd0, ev});
      check($sformatf("busy[div%0d]", divs[k]), {31'd0, (k == 0) ? b1 : b3}, {31'd0, m_phase[k] == 1});
      check($sformatf("done[div%0d]", divs[k]), {31'd0, (k == 0) ? d1 : d3}, {31'd0, m_phase[k] == 2});
      check($sformatf("state[div%0d]", divs[k]), {30'd0, (k == 0) ? s1 : s3}, {30'd0, es});
    end
    if (v1) cap_q.push_back(x1);
    if (v3) v3_cnt++;
    if (b3) b3_cnt++;
    if (d1) d1_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic clr_caps();
    cap_q.delete();
    v3_cnt = 0; b3_cnt = 0; d1_cnt = 0;
  endtask

  task automatic do_start(input logic [1:0] md, input logic signed [7:0] a, input logic [15:0] len);
    @(negedge clk);
    start = 1'b1; mode = md; amp = a; length = len;
    @(negedge clk);
    start = 1'b0; mode = $urandom_range(0, 3); amp = 8'($urandom_range(0, 255));
    length = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_phase[0] == 0 && m_phase[1] == 0 && !b1 && !b3 && !d1 && !d3) break;
    end
    n_vec++;
    if (i == 400) begin
      n_bad++;
      $display("FAIL wait_idle: got timeout expected idle within 400 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_cap(input string name, input logic [7:0] vals[$]);
    check({name, "_count"}, cap_q.size(), vals.size());
    for (int i = 0; i < vals.size() && i < cap_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), {24'd0, cap_q[i]}, {24'd0, vals[i]});
  endtask

  // ---------------- directed tests ----------------
  logic [7:0] run_a[$];

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_x_out", {24'd0, x1}, 32'd0);
    check("reset_state", {30'd0, s1}, {30'd0, ST_IDLE});

    // impulse, DIV=1 instance: 10,0,0,0,0,0 and one done
    clr_caps();
    do_start(2'd0, 8'sd10, 16'd6);
    wait_idle();
    check_cap("impulse", '{8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    check("impulse_done_pulses", d1_cnt, 1);

    // step amp=-5 on DIV=3 instance: 4 strobes, 10 busy cycles
    clr_caps();
    do_start(2'd1, -8'sd5, 16'd4);
    wait_idle();
    check("step_div3_valid", v3_cnt, 4);
    check("step_div3_busy", b3_cnt, 10);
    check_cap("step", '{8'hFB, 8'hFB, 8'hFB, 8'hFB});

    // square with saturating negation
    clr_caps();
    do_start(2'd2, -8'sd128, 16'd10);
    check("model_sq_len", exp_q.size(), 10);
    check("model_sq_0", {24'd0, exp_q[0]}, 32'h80);
    check("model_sq_4", {24'd0, exp_q[4]}, 32'h7F);
    check("model_sq_9", {24'd0, exp_q[9]}, 32'h80);
    wait_idle();
    check_cap("square", '{8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80});

    // length 0: done only
    clr_caps();
    do_start(2'd1, 8'sd10, 16'd0);
    wait_idle();
    check("len0_valid", cap_q.size(), 0);
    check("len0_done", d1_cnt, 1);

    // start while running is ignored
    clr_caps();
    do_start(2'd1, 8'sd7, 16'd5);
    @(negedge clk); start = 1'b1; mode = 2'd0; amp = 8'sd3; length = 16'd2;
    @(negedge clk); start = 1'b0;
    wait_idle();
    check_cap("busy_start", '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7});
    check("busy_start_done", d1_cnt, 1);

    // PRBS repeatability across rst, then continuation without rst
    pulse_rst();
    clr_caps();
    do_start(2'd3, 8'sd20, 16'd16);
    check("model_prbs_0", {24'd0, exp_q[0]}, 32'h14);
    check("model_prbs_1", {24'd0, exp_q[1]}, 32'hEC);
    check("model_prbs_2", {24'd0, exp_q[2]}, 32'h14);
    check("model_prbs_3", {24'd0, exp_q[3]}, 32'hEC);
    wait_idle();
    run_a = cap_q;
    pulse_rst();
    clr_caps();
    do_start(2'd3, 8'sd20, 16'd16);
    wait_idle();
    check_cap("prbs_repeat", run_a);
    clr_caps();
    do_start(2'd3, 8'sd20, 16'd16);
    wait_idle();
    check("prbs_cont_count", cap_q.size(), 16);

    // reset during the 3rd sample of a length-8 step
    clr_caps();
    do_start(2'd1, 8'sd33, 16'd8);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_x_out", {24'd0, x1}, 32'd0);
    check("midrst_valid", {31'd0, v1}, 32'd0);
    check("midrst_busy", {31'd0, b1}, 32'd0);
    check("midrst_state", {30'd0, s1}, {30'd0, ST_IDLE});
    repeat (3) @(negedge clk);
    check("midrst_no_done", d1_cnt, 0);
    clr_caps();
    do_start(2'd1, 8'sd33, 16'd8);
    wait_idle();
    check_cap("post_rst", '{8'd33, 8'd33, 8'd33, 8'd33, 8'd33, 8'd33, 8'd33, 8'd33});
    check("post_rst_done", d1_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
